id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage: consumer of the IF/ID bus driven by the fetch stage. Decodes RV32I, reads the register file, builds immediates.
//  Registers the ID/EX bundle and raises hazard_stall back to fetch on load-use or EX back-pressure.
//  One clock, one instruction per cycle, latency 1 from IF/ID to ID/EX.
// PARAMETERS
//  RESET_PC  32'h0  ID_EX_PC value on reset and bubbles
// PORTS
//  clk                      in   1   clock
//  reset_n                  in   1   asynchronous reset, active low
//  IF_ID_PC                 in   32  PC of fetched instruction
//  IF_ID_Instruction        in   32  fetched instruction
//  IF_ID_jump_branch_taken  in   1   fetch predicted taken
//  IF_ID_enable_out         in   1   IF/ID slot valid
//  hazard_flush             in   1   mispredict/redirect; kill younger work
//  ex_stall                 in   1   EX cannot accept; hold ID/EX
//  rs1_addr, rs2_addr       out  5   register file read addresses (combinational)
//  rs1_rdata, rs2_rdata     in   32  register file read data (same cycle, write-through)
//  hazard_stall             out  1   to fetch: hold IF/ID (combinational)
//  ID_EX_PC                 out  32  PC
//  ID_EX_rs1_data, ID_EX_rs2_data  out  32  operands
//  ID_EX_imm                out  32  sign-extended immediate
//  ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out  5  register indices (for forwarding)
//  ID_EX_alu_op             out  4   `ALU_* code
//  ID_EX_alu_src_imm        out  1   operand B = imm
//  ID_EX_alu_src_pc         out  1   operand A = PC (AUIPC/JAL)
//  ID_EX_mem_read, ID_EX_mem_write  out  1  load / store
//  ID_EX_mem_size           out  3   funct3 of load/store
//  ID_EX_reg_write          out  1   writes rd (forced 0 if rd==0)
//  ID_EX_wb_sel             out  2   0 ALU, 1 mem, 2 PC+4
//  ID_EX_branch, ID_EX_jump, ID_EX_jalr  out  1  control-flow class
//  ID_EX_jump_branch_taken  out  1   prediction, passed through
//  ID_EX_illegal            out  1   illegal opcode flag (see CONFIGURATION)
//  ID_EX_enable_out         out  1   ID/EX slot valid
// BEHAVIOUR
//  - Reset: all ID_EX_* = 0 except ID_EX_PC = RESET_PC; replay = 0; hazard_stall = 0.
//  - replay flag: fetch holds the instruction on a stall but drops IF_ID_enable_out. valid_in = IF_ID_enable_out | replay.
//  - load_use = ID_EX_enable_out & ID_EX_mem_read & ID_EX_rd!=0 & ((rs1_used & ID_EX_rd==rs1) | (rs2_used & ID_EX_rd==rs2)).
//  - hazard_stall = valid_in & ~hazard_flush & (load_use | ex_stall).
//  - Per-edge priority:
//    1. hazard_flush: ID/EX becomes a bubble (enable/mem/reg_write/branch/jump/illegal = 0); replay <= 0.
//    2. ex_stall: ID/EX holds all fields; replay <= valid_in.
//    3. load_use: ID/EX becomes a bubble; replay <= 1.
//    4. Otherwise: ID/EX <= decode(valid_in); replay <= 0.
//  - Load-use stalls exactly 1 cycle, since the bubble clears mem_read.
//  - Invalid input (valid_in=0) decodes as a bubble.
//  - rs1_used: JALR, BRANCH, LOAD, STORE, OP-IMM, OP. rs2_used: BRANCH, STORE, OP. Unused indices still drive ID_EX_rs* with instruction bits.
//  - Immediates (formats I/S/B/U/J) are sign-extended from inst[31]. B/J imm[0]=0; U low 12 bits = 0.
//  - Instruction classes:
//    - LUI: alu_op=`ALU_PASSB.
//    - JAL/JALR: wb_sel=2.
//    - FENCE, ECALL, EBREAK: NOP, no side effects.
//    - OP funct7: 0000000 or 0100000 only (SUB/SRA); shift-imm funct7 rule likewise.
// CONFIGURATION
//  ID_ILLEGAL_DETECT_EN
//  - Defined: unknown opcode, bad funct7, or inst[1:0]!=2'b11 sets ID_EX_illegal=1 with enable_out=1 and all side-effect controls 0.
//  - Undefined: ID_EX_illegal tied 0; such instructions issue as NOP.
// STRUCTURE
//  - common.vh gains `OPC_* opcodes, `ALU_* codes, `WB_* selects and `NOP_INST (32'h00000013).
//  - Sub-module id_decoder: combinational decode plus immediates and the rs*_used flags.
//  - id_stage holds the hazard logic, replay and the ID/EX register.
// TESTING
//  1. ADDI x1,x0,5 (32'h00500093) valid at PC 0x10 -> next cycle enable=1, rd=1, imm=5, alu_src_imm=1, reg_write=1, PC=0x10.
//  2. LW x2,0(x1) then ADD x3,x2,x2 -> hazard_stall=1 for 1 cycle, bubble in ID/EX.
//     ADD issues the following cycle via replay, with IF_ID_enable_out=0.
//  3. hazard_flush with valid ADD in ID -> ID/EX enable=0, reg_write=0, replay cleared.
//     Flush with load_use pending -> hazard_stall=0.
//  4. ex_stall=1 for 3 cycles with BEQ valid -> ID/EX frozen, hazard_stall=1 throughout.
//     BEQ issues the cycle after release; B-imm -8 = 32'hFFFFFFF8.
//  5. ADD x0,x1,x2 -> reg_write=0. LUI x5,0xABCDE -> imm=32'hABCDE000. JAL x1,-4 -> imm=32'hFFFFFFFC, wb_sel=2, jump=1.
//  6. Inst 32'hFFFFFFFF -> with ID_ILLEGAL_DETECT_EN: illegal=1, mem/reg_write=0. Without: NOP.
//     Assert reset_n low mid-stall -> all outputs reset, hazard_stall=0.

Source files
------------

// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared opcodes, ALU codes, write-back selects and decode
// record types for the RV32I decode stage.
package id_stage_pkg;

   // RV32I major opcodes (inst[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Write-back source selects
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   // Canonical NOP: ADDI x0,x0,0
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   // Combinational decode result for one instruction
   typedef struct packed {
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      alu_op_e     alu_op;
      logic        alu_src_imm;
      logic        alu_src_pc;
      logic        mem_read;
      logic        mem_write;
      logic [2:0]  mem_size;
      logic        reg_write;
      logic [1:0]  wb_sel;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic        illegal;
      logic        rs1_used;
      logic        rs2_used;
   } dec_t;

   // Contents of the ID/EX pipeline register
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      alu_op_e     alu_op;
      logic        alu_src_imm;
      logic        alu_src_pc;
      logic        mem_read;
      logic        mem_write;
      logic [2:0]  mem_size;
      logic        reg_write;
      logic [1:0]  wb_sel;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic        jump_branch_taken;
      logic        illegal;
      logic        enable;
   } idex_t;

   // ALU operation for OP / OP-IMM; alt selects SUB/SRA
   function automatic alu_op_e alu_op_from_funct(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         3'd0:    if (alt) op = ALU_SUB; else op = ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    if (alt) op = ALU_SRA; else op = ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // funct7 legality: 0100000 is only meaningful for SRA(I) and register SUB
   function automatic logic funct7_ok(input logic [2:0] f3, input logic [6:0] f7, input logic is_reg);
      logic ok;
      ok = 1'b0;
      if (f7 == 7'b0000000)
         ok = 1'b1;
      else if (f7 == 7'b0100000)
         ok = (f3 == 3'd5) || (is_reg && (f3 == 3'd0));
      return ok;
   endfunction

endpackage

// File: rtl/id_decoder.sv
// id_decoder: purely combinational RV32I decode. Produces control fields,
// sign-extended immediates and the rs1/rs2 usage flags for hazard checks.
// Optional feature macro: ID_ILLEGAL_DETECT_EN (flag illegal encodings
// instead of silently issuing them as NOPs).
module id_decoder
   import id_stage_pkg::*;
(
   input  logic [31:0] inst_i,
   output dec_t        dec_o
);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        bad;
   dec_t        d;

   assign opcode = inst_i[6:0];
   assign f3     = inst_i[14:12];
   assign f7     = inst_i[31:25];

   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'h000};
   assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   // Opcode decode; any illegal encoding collapses to a side-effect-free NOP
   always_comb begin
      d          = '0;
      bad        = (inst_i[1:0] != 2'b11);
      d.rs1      = inst_i[19:15];
      d.rs2      = inst_i[24:20];
      d.rd       = inst_i[11:7];
      d.mem_size = f3;
      d.alu_op   = ALU_ADD;
      d.wb_sel   = WB_ALU;
      d.imm      = imm_i;
      case (opcode)
         OPC_LUI: begin
            d.imm = imm_u; d.alu_op = ALU_PASSB; d.alu_src_imm = 1'b1; d.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            d.imm = imm_u; d.alu_src_pc = 1'b1; d.alu_src_imm = 1'b1; d.reg_write = 1'b1;
         end
         OPC_JAL: begin
            d.imm = imm_j; d.alu_src_pc = 1'b1; d.alu_src_imm = 1'b1;
            d.jump = 1'b1; d.reg_write = 1'b1; d.wb_sel = WB_PC4;
         end
         OPC_JALR: begin
            d.rs1_used = 1'b1; d.alu_src_imm = 1'b1;
            d.jalr = 1'b1; d.reg_write = 1'b1; d.wb_sel = WB_PC4;
            bad = bad | (f3 != 3'd0);
         end
         OPC_BRANCH: begin
            d.imm = imm_b; d.rs1_used = 1'b1; d.rs2_used = 1'b1;
            d.branch = 1'b1; d.alu_op = ALU_SUB;
            bad = bad | (f3 == 3'd2) | (f3 == 3'd3);
         end
         OPC_LOAD: begin
            d.rs1_used = 1'b1; d.alu_src_imm = 1'b1;
            d.mem_read = 1'b1; d.reg_write = 1'b1; d.wb_sel = WB_MEM;
            bad = bad | (f3 == 3'd3) | (f3 >= 3'd6);
         end
         OPC_STORE: begin
            d.imm = imm_s; d.rs1_used = 1'b1; d.rs2_used = 1'b1;
            d.alu_src_imm = 1'b1; d.mem_write = 1'b1;
            bad = bad | (f3 > 3'd2);
         end
         OPC_OP_IMM: begin
            d.rs1_used = 1'b1; d.alu_src_imm = 1'b1; d.reg_write = 1'b1;
            d.alu_op = alu_op_from_funct(f3, (f3 == 3'd5) && f7[5]);
            if ((f3 == 3'd1) || (f3 == 3'd5))
               bad = bad | !funct7_ok(f3, f7, 1'b0);
         end
         OPC_OP: begin
            d.rs1_used = 1'b1; d.rs2_used = 1'b1; d.reg_write = 1'b1;
            d.alu_op = alu_op_from_funct(f3, f7[5]);
            bad = bad | !funct7_ok(f3, f7, 1'b1);
         end
         OPC_FENCE, OPC_SYSTEM: begin
            // Treated as NOPs: no register, memory or control-flow effect
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         d.rs1_used    = 1'b0;
         d.rs2_used    = 1'b0;
         d.alu_src_imm = 1'b0;
         d.alu_src_pc  = 1'b0;
         d.mem_read    = 1'b0;
         d.mem_write   = 1'b0;
         d.reg_write   = 1'b0;
         d.branch      = 1'b0;
         d.jump        = 1'b0;
         d.jalr        = 1'b0;
         d.wb_sel      = WB_ALU;
         d.alu_op      = ALU_ADD;
      end
`ifdef ID_ILLEGAL_DETECT_EN
      d.illegal = bad;
`else
      d.illegal = 1'b0;
`endif
      // x0 is hard-wired zero, so writes to it are dropped here
      if (d.rd == 5'd0)
         d.reg_write = 1'b0;
   end

   assign dec_o = d;

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage. Reads the register file, registers the ID/EX
// bundle and stalls fetch on load-use hazards or EX back-pressure.
// Optional feature macro: ID_ILLEGAL_DETECT_EN (see id_decoder).
module id_stage
   import id_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] IF_ID_PC,
   input  logic [31:0] IF_ID_Instruction,
   input  logic        IF_ID_jump_branch_taken,
   input  logic        IF_ID_enable_out,
   input  logic        hazard_flush,
   input  logic        ex_stall,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_rdata,
   input  logic [31:0] rs2_rdata,
   output logic        hazard_stall,
   output logic [31:0] ID_EX_PC,
   output logic [31:0] ID_EX_rs1_data,
   output logic [31:0] ID_EX_rs2_data,
   output logic [31:0] ID_EX_imm,
   output logic [4:0]  ID_EX_rs1,
   output logic [4:0]  ID_EX_rs2,
   output logic [4:0]  ID_EX_rd,
   output logic [3:0]  ID_EX_alu_op,
   output logic        ID_EX_alu_src_imm,
   output logic        ID_EX_alu_src_pc,
   output logic        ID_EX_mem_read,
   output logic        ID_EX_mem_write,
   output logic [2:0]  ID_EX_mem_size,
   output logic        ID_EX_reg_write,
   output logic [1:0]  ID_EX_wb_sel,
   output logic        ID_EX_branch,
   output logic        ID_EX_jump,
   output logic        ID_EX_jalr,
   output logic        ID_EX_jump_branch_taken,
   output logic        ID_EX_illegal,
   output logic        ID_EX_enable_out,
   output logic        ID_EX_enable_out_unused_guard_n
);

   dec_t  dec;
   idex_t id_ex_q, id_ex_d, issue;
   logic  replay_q, replay_d;
   logic  valid_in;
   logic  load_use;

   // Empty ID/EX slot: nothing valid, no side effects, PC parked at RESET_PC
   function automatic idex_t bubble();
      idex_t b;
      b    = '0;
      b.pc = RESET_PC;
      return b;
   endfunction

   id_decoder u_decoder (
      .inst_i (IF_ID_Instruction),
      .dec_o  (dec)
   );

   assign rs1_addr = dec.rs1;
   assign rs2_addr = dec.rs2;

   // Fetch drops its valid while holding a stalled instruction; replay restores it
   assign valid_in = IF_ID_enable_out | replay_q;

   assign load_use = id_ex_q.enable & id_ex_q.mem_read & (id_ex_q.rd != 5'd0) &
                     ((dec.rs1_used & (id_ex_q.rd == dec.rs1)) |
                      (dec.rs2_used & (id_ex_q.rd == dec.rs2)));

   // Reset forces the stall low even while fetch still presents a valid slot
   assign hazard_stall = reset_n & valid_in & ~hazard_flush & (load_use | ex_stall);

   // Build the ID/EX record for the instruction currently in ID
   always_comb begin
      issue = bubble();
      if (valid_in) begin
         issue.pc                = IF_ID_PC;
         issue.rs1_data          = rs1_rdata;
         issue.rs2_data          = rs2_rdata;
         issue.imm               = dec.imm;
         issue.rs1               = dec.rs1;
         issue.rs2               = dec.rs2;
         issue.rd                = dec.rd;
         issue.alu_op            = dec.alu_op;
         issue.alu_src_imm       = dec.alu_src_imm;
         issue.alu_src_pc        = dec.alu_src_pc;
         issue.mem_read          = dec.mem_read;
         issue.mem_write         = dec.mem_write;
         issue.mem_size          = dec.mem_size;
         issue.reg_write         = dec.reg_write;
         issue.wb_sel            = dec.wb_sel;
         issue.branch            = dec.branch;
         issue.jump              = dec.jump;
         issue.jalr              = dec.jalr;
         issue.jump_branch_taken = IF_ID_jump_branch_taken;
         issue.illegal           = dec.illegal;
         issue.enable            = 1'b1;
      end
   end

   // Next-state priority: flush, then EX hold, then load-use bubble, then issue.
   // Load-use only bites on a valid instruction; an empty slot must not arm replay.
   always_comb begin
      id_ex_d  = id_ex_q;
      replay_d = 1'b0;
      if (hazard_flush) begin
         id_ex_d = bubble();
      end else if (ex_stall) begin
         replay_d = valid_in;
      end else if (valid_in && load_use) begin
         id_ex_d  = bubble();
         replay_d = 1'b1;
      end else begin
         id_ex_d = issue;
      end
   end

   // ID/EX pipeline register and replay flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         id_ex_q  <= bubble();
         replay_q <= 1'b0;
      end else begin
         id_ex_q  <= id_ex_d;
         replay_q <= replay_d;
      end
   end

   assign ID_EX_PC                = id_ex_q.pc;
   assign ID_EX_rs1_data          = id_ex_q.rs1_data;
   assign ID_EX_rs2_data          = id_ex_q.rs2_data;
   assign ID_EX_imm               = id_ex_q.imm;
   assign ID_EX_rs1               = id_ex_q.rs1;
   assign ID_EX_rs2               = id_ex_q.rs2;
   assign ID_EX_rd                = id_ex_q.rd;
   assign ID_EX_alu_op            = id_ex_q.alu_op;
   assign ID_EX_alu_src_imm       = id_ex_q.alu_src_imm;
   assign ID_EX_alu_src_pc        = id_ex_q.alu_src_pc;
   assign ID_EX_mem_read          = id_ex_q.mem_read;
   assign ID_EX_mem_write         = id_ex_q.mem_write;
   assign ID_EX_mem_size          = id_ex_q.mem_size;
   assign ID_EX_reg_write         = id_ex_q.reg_write;
   assign ID_EX_wb_sel            = id_ex_q.wb_sel;
   assign ID_EX_branch            = id_ex_q.branch;
   assign ID_EX_jump              = id_ex_q.jump;
   assign ID_EX_jalr              = id_ex_q.jalr;
   assign ID_EX_jump_branch_taken = id_ex_q.jump_branch_taken;
   assign ID_EX_illegal           = id_ex_q.illegal;
   assign ID_EX_enable_out        = id_ex_q.enable;
   assign ID_EX_enable_out_unused_guard_n = ~id_ex_q.enable;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage.
// Honours ID_ILLEGAL_DETECT_EN the same way the RTL does.
module tb_id_stage;
   import id_stage_pkg::*;

   localparam logic [31:0] RST_PC    = 32'h0000_0100;
   localparam logic [31:0] I_ADDI    = 32'h0050_0093; // ADDI x1,x0,5
   localparam logic [31:0] I_LW      = 32'h0000_A103; // LW x2,0(x1)
   localparam logic [31:0] I_ADD     = 32'h0021_01B3; // ADD x3,x2,x2
   localparam logic [31:0] I_BEQ     = 32'hFE20_8CE3; // BEQ x1,x2,-8
   localparam logic [31:0] I_ADD_X0  = 32'h0020_8033; // ADD x0,x1,x2
   localparam logic [31:0] I_LUI     = 32'hABCD_E2B7; // LUI x5,0xABCDE
   localparam logic [31:0] I_JAL     = 32'hFFDF_F0EF; // JAL x1,-4
   localparam logic [31:0] I_BAD     = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] IF_ID_PC, IF_ID_Instruction;
   logic        IF_ID_jump_branch_taken, IF_ID_enable_out;
   logic        hazard_flush, ex_stall;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_rdata, rs2_rdata;
   logic        hazard_stall;
   logic [31:0] ID_EX_PC, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
   logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
   logic [3:0]  ID_EX_alu_op;
   logic        ID_EX_alu_src_imm, ID_EX_alu_src_pc, ID_EX_mem_read, ID_EX_mem_write;
   logic [2:0]  ID_EX_mem_size;
   logic        ID_EX_reg_write;
   logic [1:0]  ID_EX_wb_sel;
   logic        ID_EX_branch, ID_EX_jump, ID_EX_jalr, ID_EX_jump_branch_taken;
   logic        ID_EX_illegal, ID_EX_enable_out, ID_EX_enable_out_unused_guard_n;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   // Register file model: xN reads as N*32
   assign rs1_rdata = {22'h0, rs1_addr, 5'h0};
   assign rs2_rdata = {22'h0, rs2_addr, 5'h0};

   id_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset_n(reset_n),
      .IF_ID_PC(IF_ID_PC), .IF_ID_Instruction(IF_ID_Instruction),
      .IF_ID_jump_branch_taken(IF_ID_jump_branch_taken), .IF_ID_enable_out(IF_ID_enable_out),
      .hazard_flush(hazard_flush), .ex_stall(ex_stall),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
      .hazard_stall(hazard_stall),
      .ID_EX_PC(ID_EX_PC), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
      .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
      .ID_EX_alu_op(ID_EX_alu_op), .ID_EX_alu_src_imm(ID_EX_alu_src_imm),
      .ID_EX_alu_src_pc(ID_EX_alu_src_pc), .ID_EX_mem_read(ID_EX_mem_read),
      .ID_EX_mem_write(ID_EX_mem_write), .ID_EX_mem_size(ID_EX_mem_size),
      .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_wb_sel(ID_EX_wb_sel),
      .ID_EX_branch(ID_EX_branch), .ID_EX_jump(ID_EX_jump), .ID_EX_jalr(ID_EX_jalr),
      .ID_EX_jump_branch_taken(ID_EX_jump_branch_taken), .ID_EX_illegal(ID_EX_illegal),
      .ID_EX_enable_out(ID_EX_enable_out),
      .ID_EX_enable_out_unused_guard_n(ID_EX_enable_out_unused_guard_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic en);
      IF_ID_PC          = pc;
      IF_ID_Instruction = inst;
      IF_ID_enable_out  = en;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(32'h0, NOP_INST, 1'b0);
      tick(); tick();
      total++; if (ID_EX_enable_out !== 1'b0) $display("FAIL rst_enable got %b exp 0", ID_EX_enable_out); else passed++;
      total++; if (ID_EX_PC !== RST_PC) $display("FAIL rst_pc got %h exp %h", ID_EX_PC, RST_PC); else passed++;
      total++; if (ID_EX_reg_write !== 1'b0) $display("FAIL rst_reg_write got %b exp 0", ID_EX_reg_write); else passed++;
      total++; if (ID_EX_imm !== 32'h0) $display("FAIL rst_imm got %h exp 0", ID_EX_imm); else passed++;
      total++; if (hazard_stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", hazard_stall); else passed++;
      reset_n = 1'b1;
      tick();
      $display("test_reset: released, ID_EX_PC=%h", ID_EX_PC);
   endtask

   task automatic test_addi();
      drive(32'h10, I_ADDI, 1'b1);
      tick();
      total++; if (ID_EX_enable_out !== 1'b1) $display("FAIL addi_enable got %b exp 1", ID_EX_enable_out); else passed++;
      total++; if (ID_EX_rd !== 5'd1) $display("FAIL addi_rd got %0d exp 1", ID_EX_rd); else passed++;
      total++; if (ID_EX_imm !== 32'd5) $display("FAIL addi_imm got %h exp 5", ID_EX_imm); else passed++;
      total++; if (ID_EX_alu_src_imm !== 1'b1) $display("FAIL addi_src_imm got %b exp 1", ID_EX_alu_src_imm); else passed++;
      total++; if (ID_EX_reg_write !== 1'b1) $display("FAIL addi_reg_write got %b exp 1", ID_EX_reg_write); else passed++;
      total++; if (ID_EX_PC !== 32'h10) $display("FAIL addi_pc got %h exp 10", ID_EX_PC); else passed++;
      total++; if (ID_EX_alu_op !== ALU_ADD) $display("FAIL addi_alu_op got %0d exp %0d", ID_EX_alu_op, ALU_ADD); else passed++;
      drive(32'h0, NOP_INST, 1'b0);
      $display("test_addi: pc=%h rd=%0d imm=%h", ID_EX_PC, ID_EX_rd, ID_EX_imm);
   endtask

   task automatic test_load_use();
      drive(32'h14, I_LW, 1'b1);
      tick();
      total++; if (ID_EX_mem_read !== 1'b1) $display("FAIL lw_mem_read got %b exp 1", ID_EX_mem_read); else passed++;
      total++; if (ID_EX_wb_sel !== WB_MEM) $display("FAIL lw_wb_sel got %0d exp 1", ID_EX_wb_sel); else passed++;
      total++; if (ID_EX_mem_size !== 3'd2) $display("FAIL lw_mem_size got %0d exp 2", ID_EX_mem_size); else passed++;
      drive(32'h18, I_ADD, 1'b1);
      #1;
      total++; if (hazard_stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", hazard_stall); else passed++;
      tick();
      total++; if (ID_EX_enable_out !== 1'b0) $display("FAIL lu_bubble_en got %b exp 0", ID_EX_enable_out); else passed++;
      total++; if (ID_EX_mem_read !== 1'b0) $display("FAIL lu_bubble_mr got %b exp 0", ID_EX_mem_read); else passed++;
      IF_ID_enable_out = 1'b0;
      #1;
      total++; if (hazard_stall !== 1'b0) $display("FAIL lu_stall_once got %b exp 0", hazard_stall); else passed++;
      tick();
      total++; if (ID_EX_enable_out !== 1'b1) $display("FAIL replay_en got %b exp 1", ID_EX_enable_out); else passed++;
      total++; if (ID_EX_rd !== 5'd3) $display("FAIL replay_rd got %0d exp 3", ID_EX_rd); else passed++;
      total++; if (ID_EX_PC !== 32'h18) $display("FAIL replay_pc got %h exp 18", ID_EX_PC); else passed++;
      total++; if (ID_EX_rs1_data !== 32'h40) $display("FAIL replay_rs1d got %h exp 40", ID_EX_rs1_data); else passed++;
      total++; if (ID_EX_rs2_data !== 32'h40) $display("FAIL replay_rs2d got %h exp 40", ID_EX_rs2_data); else passed++;
      drive(32'h0, NOP_INST, 1'b0);
      tick();
      total++; if (ID_EX_enable_out !== 1'b0) $display("FAIL replay_once got %b exp 0", ID_EX_enable_out); else passed++;
      $display("test_load_use: ADD replayed after one bubble");
   endtask

   task automatic test_flush();
      drive(32'h30, I_ADD, 1'b1);
      hazard_flush = 1'b1;
      tick();
      total++; if (ID_EX_enable_out !== 1'b0) $display("FAIL flush_en got %b exp 0", ID_EX_enable_out); else passed++;
      total++; if (ID_EX_reg_write !== 1'b0) $display("FAIL flush_rw got %b exp 0", ID_EX_reg_write); else passed++;
      hazard_flush = 1'b0;
      drive(32'h0, NOP_INST, 1'b0);
      tick();
      total++; if (ID_EX_enable_out !== 1'b0) $display("FAIL flush_noreplay got %b exp 0", ID_EX_enable_out); else passed++;
      drive(32'h34, I_LW, 1'b1);
      tick();
      drive(32'h38, I_ADD, 1'b1);
      hazard_flush = 1'b1;
      #1;
      total++; if (hazard_stall !== 1'b0) $display("FAIL flush_lu_stall got %b exp 0", hazard_stall); else passed++;
      tick();
      total++; if (ID_EX_mem_read !== 1'b0) $display("FAIL flush_lu_mr got %b exp 0", ID_EX_mem_read); else passed++;
      hazard_flush = 1'b0;
      drive(32'h0, NOP_INST, 1'b0);
      tick();
      total++; if (ID_EX_enable_out !== 1'b0) $display("FAIL flush_lu_noreplay got %b exp 0", ID_EX_enable_out); else passed++;
      $display("test_flush: flushed ADD and load-use pair");
   endtask

   task automatic test_ex_stall();
      drive(32'h20, I_ADDI, 1'b1);
      tick();
      drive(32'h24, I_BEQ, 1'b1);
      IF_ID_jump_branch_taken = 1'b1;
      ex_stall = 1'b1;
      #1;
      total++; if (hazard_stall !== 1'b1) $display("FAIL exs_stall0 got %b exp 1", hazard_stall); else passed++;
      for (int i = 0; i < 3; i++) begin
         tick();
         IF_ID_enable_out = 1'b0;
         #1;
         total++; if (ID_EX_PC !== 32'h20) $display("FAIL exs_hold_pc%0d got %h exp 20", i, ID_EX_PC); else passed++;
         total++; if (ID_EX_rd !== 5'd1) $display("FAIL exs_hold_rd%0d got %0d exp 1", i, ID_EX_rd); else passed++;
         total++; if (ID_EX_branch !== 1'b0) $display("FAIL exs_hold_br%0d got %b exp 0", i, ID_EX_branch); else passed++;
         total++; if (hazard_stall !== 1'b1) $display("FAIL exs_stall%0d got %b exp 1", i + 1, hazard_stall); else passed++;
      end
      ex_stall = 1'b0;
      #1;
      total++; if (hazard_stall !== 1'b0) $display("FAIL exs_release got %b exp 0", hazard_stall); else passed++;
      tick();
      total++; if (ID_EX_branch !== 1'b1) $display("FAIL beq_branch got %b exp 1", ID_EX_branch); else passed++;
      total++; if (ID_EX_PC !== 32'h24) $display("FAIL beq_pc got %h exp 24", ID_EX_PC); else passed++;
      total++; if (ID_EX_imm !== 32'hFFFF_FFF8) $display("FAIL beq_imm got %h exp fffffff8", ID_EX_imm); else passed++;
      total++; if (ID_EX_jump_branch_taken !== 1'b1) $display("FAIL beq_jbt got %b exp 1", ID_EX_jump_branch_taken); else passed++;
      total++; if (ID_EX_reg_write !== 1'b0) $display("FAIL beq_rw got %b exp 0", ID_EX_reg_write); else passed++;
      IF_ID_jump_branch_taken = 1'b0;
      drive(32'h0, NOP_INST, 1'b0);
      $display("test_ex_stall: BEQ issued after 3-cycle hold, imm=%h", ID_EX_imm);
   endtask

   task automatic test_decode_mix();
      drive(32'h40, I_ADD_X0, 1'b1);
      tick();
      total++; if (ID_EX_enable_out !== 1'b1) $display("FAIL addx0_en got %b exp 1", ID_EX_enable_out); else passed++;
      total++; if (ID_EX_reg_write !== 1'b0) $display("FAIL addx0_rw got %b exp 0", ID_EX_reg_write); else passed++;
      drive(32'h44, I_LUI, 1'b1);
      tick();
      total++; if (ID_EX_imm !== 32'hABCD_E000) $display("FAIL lui_imm got %h exp abcde000", ID_EX_imm); else passed++;
      total++; if (ID_EX_alu_op !== ALU_PASSB) $display("FAIL lui_alu got %0d exp %0d", ID_EX_alu_op, ALU_PASSB); else passed++;
      total++; if (ID_EX_rd !== 5'd5) $display("FAIL lui_rd got %0d exp 5", ID_EX_rd); else passed++;
      drive(32'h48, I_JAL, 1'b1);
      tick();
      total++; if (ID_EX_imm !== 32'hFFFF_FFFC) $display("FAIL jal_imm got %h exp fffffffc", ID_EX_imm); else passed++;
      total++; if (ID_EX_wb_sel !== WB_PC4) $display("FAIL jal_wb got %0d exp 2", ID_EX_wb_sel); else passed++;
      total++; if (ID_EX_jump !== 1'b1) $display("FAIL jal_jump got %b exp 1", ID_EX_jump); else passed++;
      total++; if (ID_EX_reg_write !== 1'b1) $display("FAIL jal_rw got %b exp 1", ID_EX_reg_write); else passed++;
      total++; if (ID_EX_alu_src_pc !== 1'b1) $display("FAIL jal_src_pc got %b exp 1", ID_EX_alu_src_pc); else passed++;
      drive(32'h0, NOP_INST, 1'b0);
      $display("test_decode_mix: ADD x0, LUI, JAL decoded");
   endtask

   task automatic test_illegal_and_reset();
      drive(32'h50, I_BAD, 1'b1);
      tick();
      total++; if (ID_EX_enable_out !== 1'b1) $display("FAIL bad_en got %b exp 1", ID_EX_enable_out); else passed++;
`ifdef ID_ILLEGAL_DETECT_EN
      total++; if (ID_EX_illegal !== 1'b1) $display("FAIL bad_illegal got %b exp 1", ID_EX_illegal); else passed++;
`else
      total++; if (ID_EX_illegal !== 1'b0) $display("FAIL bad_illegal got %b exp 0", ID_EX_illegal); else passed++;
`endif
      total++; if (ID_EX_reg_write !== 1'b0) $display("FAIL bad_rw got %b exp 0", ID_EX_reg_write); else passed++;
      total++; if (ID_EX_mem_read !== 1'b0) $display("FAIL bad_mr got %b exp 0", ID_EX_mem_read); else passed++;
      total++; if (ID_EX_mem_write !== 1'b0) $display("FAIL bad_mw got %b exp 0", ID_EX_mem_write); else passed++;
      drive(32'h54, I_LW, 1'b1);
      tick();
      drive(32'h58, I_ADD, 1'b1);
      ex_stall = 1'b1;
      #1;
      total++; if (hazard_stall !== 1'b1) $display("FAIL pre_rst_stall got %b exp 1", hazard_stall); else passed++;
      reset_n = 1'b0;
      #1;
      total++; if (hazard_stall !== 1'b0) $display("FAIL midrst_stall got %b exp 0", hazard_stall); else passed++;
      total++; if (ID_EX_enable_out !== 1'b0) $display("FAIL midrst_en got %b exp 0", ID_EX_enable_out); else passed++;
      total++; if (ID_EX_PC !== RST_PC) $display("FAIL midrst_pc got %h exp %h", ID_EX_PC, RST_PC); else passed++;
      total++; if (ID_EX_mem_read !== 1'b0) $display("FAIL midrst_mr got %b exp 0", ID_EX_mem_read); else passed++;
      total++; if (ID_EX_rd !== 5'd0) $display("FAIL midrst_rd got %0d exp 0", ID_EX_rd); else passed++;
      tick();
      reset_n  = 1'b1;
      ex_stall = 1'b0;
      drive(32'h0, NOP_INST, 1'b0);
      tick();
      total++; if (ID_EX_enable_out !== 1'b0) $display("FAIL postrst_noreplay got %b exp 0", ID_EX_enable_out); else passed++;
      $display("test_illegal_and_reset: illegal=%b, reset mid-stall done", ID_EX_illegal);
   endtask

   initial begin
      reset_n                 = 1'b0;
      IF_ID_PC                = 32'h0;
      IF_ID_Instruction       = NOP_INST;
      IF_ID_jump_branch_taken = 1'b0;
      IF_ID_enable_out        = 1'b0;
      hazard_flush            = 1'b0;
      ex_stall                = 1'b0;
      test_reset();
      test_addi();
      test_load_use();
      test_flush();
      test_ex_stall();
      test_decode_mix();
      test_illegal_and_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
